hex_display_arbiter: RTL

Time-shares one N-digit hex display between several requesters, such as a counter, a debug register or a switch readback. It grants one requester at a time using round-robin priority and latches that requester's hex word. The word is held on the display for a fixed dwell time before the display is re-arbitrated. The block drives the `hex` bus of the downstream N-digit hex-to-seven-segment encoder and is the only writer of that bus.

---
 rtl/hex_display_pkg.sv | 31 +++
 rtl/hex_display_arbiter_rr_arbiter.sv | 44 ++++
 rtl/hex_display_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display arbiter.
// Holds the FSM state encodings and the clog2 helper that sizes the
// counter and pointer widths.
package hex_display_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Width helper that never returns zero.
  function automatic int unsigned width_of(input int unsigned v);
    int unsigned w;
    w = clog2(v);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/hex_display_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   i_req       request vector, one bit per requester
//   i_ptr       index of the highest-priority requester this round
//   o_grant     one-hot grant (all zero when no request)
//   o_grant_idx binary index of the winner
//   o_any       any request present
module rr_arbiter
  import hex_display_pkg::*;
#(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned PTR_W      = width_of(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] i_req,
  input  logic [PTR_W-1:0]      i_ptr,
  output logic [REQUESTERS-1:0] o_grant,
  output logic [PTR_W-1:0]      o_grant_idx,
  output logic                  o_any
);

  logic [2*REQUESTERS-1:0] w_dbl;
  logic [REQUESTERS-1:0]   w_rot;
  logic [PTR_W-1:0]        w_off;
  logic [PTR_W:0]          w_sum;

  // Rotate requests so bit 0 is the requester at i_ptr.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[REQUESTERS-1:0];

  // Lowest set bit of the rotated vector, mapped back to an absolute index.
  always_comb begin
    w_off = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = PTR_W'(i);
    end
    w_sum = (PTR_W+1)'(w_off) + (PTR_W+1)'(i_ptr);
    if (w_sum >= (PTR_W+1)'(REQUESTERS)) w_sum = w_sum - (PTR_W+1)'(REQUESTERS);
  end

  assign o_any       = |i_req;
  assign o_grant_idx = PTR_W'(w_sum);
  assign o_grant     = o_any ? (REQUESTERS'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/hex_display_arbiter.sv
// Time-shares one hex display between several requesters.
// A round-robin winner's word is latched and held for DWELL_CYCLES cycles;
// in the last dwell cycle the block re-arbitrates so back-to-back grants
// give every word exactly DWELL_CYCLES cycles on the display.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   req_valid     per-requester word-available flags
//   req_hex       packed requester words, requester r at slice r
//   req_ready     one-hot combinational accept strobe
//   hex           registered display word
//   owner         registered one-hot owner of the displayed word
//   active        registered dwell-in-progress flag
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned DIGITS       = 6,
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [REQUESTERS-1:0]          req_valid,
  input  logic [REQUESTERS*4*DIGITS-1:0] req_hex,
  output logic [REQUESTERS-1:0]          req_ready,
  output logic [4*DIGITS-1:0]            hex,
  output logic [REQUESTERS-1:0]          owner,
  output logic                           active
);

  localparam int unsigned HEX_W = 4 * DIGITS;
  localparam int unsigned CNT_W = width_of(DWELL_CYCLES);
  localparam int unsigned PTR_W = width_of(REQUESTERS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [PTR_W-1:0]      r_ptr;
  logic [HEX_W-1:0]      r_hex;
  logic [REQUESTERS-1:0] r_owner;
  logic                  r_active;

  logic [REQUESTERS-1:0] w_grant;
  logic [PTR_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_arb_en;
  logic                  w_fire;
  logic [REQUESTERS-1:0] w_ready;

  rr_arbiter #(
    .REQUESTERS (REQUESTERS),
    .PTR_W      (PTR_W)
  ) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx),
    .o_any       (w_any)
  );

  // Arbitration window: idle, or the final cycle of a dwell.
  assign w_arb_en = (r_state == ST_IDLE) || (r_cnt == '0);
  assign w_fire   = w_arb_en && w_any && !reset;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (w_arb_en) w_state_nxt = w_any ? ST_DWELL : ST_IDLE;
  end

  // Output logic: ready is combinational and suppressed during reset.
  always_comb begin
    w_ready = '0;
    if (w_arb_en && !reset) w_ready = w_grant;
  end

  // Dwell counter, display word, owner and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_hex    <= '0;
      r_owner  <= '0;
      r_active <= 1'b0;
    end else if (w_fire) begin
      r_hex    <= req_hex[w_idx*HEX_W +: HEX_W];
      r_owner  <= w_grant;
      r_active <= 1'b1;
      r_cnt    <= CNT_W'(DWELL_CYCLES - 1);
      r_ptr    <= (w_idx == PTR_W'(REQUESTERS - 1)) ? '0 : w_idx + PTR_W'(1);
    end else if (r_state == ST_DWELL) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      else             r_active <= 1'b0;
    end
  end

  assign req_ready = w_ready;
  assign hex       = r_hex;
  assign owner     = r_owner;
  assign active    = r_active;

endmodule
